// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way mux arbiter.
// Select codes follow the mux wiring: owner index = {s2,s1}.
package mux4_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requests.
// Searches ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit wins.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] k;

  // Walk from the farthest slot back so the nearest hit lands last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    k     = ptr;
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4x1 mux.
// Drives the mux selects and captures the selected output.
import mux4_arb_pkg::*;

module mux4_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s2,
  input  logic [3:0] e,
  output logic       busy,
  output logic [3:0] dout,
  output logic       dout_vld,
  output logic [1:0] dout_src
);

  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      ptr;
  logic [CW-1:0]   cnt;
  logic [1:0]      pick_ptr;
  logic [1:0]      win;
  logic            found;
  logic            rearb;

  assign rearb = !req[owner] || (cnt == LAST);

  // Searching from owner+1 leaves the old owner as the last resort.
  assign pick_ptr = (state == GRANT) ? owner + 2'd1 : ptr;

  assign busy = |gnt;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= SEL_A;
      ptr      <= SEL_A;
      cnt      <= '0;
      gnt      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_src <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            owner    <= win;
            gnt      <= onehot4(win);
            {s2, s1} <= win;
            cnt      <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rearb) begin
            ptr <= owner + 2'd1;
            if (found) begin
              owner    <= win;
              gnt      <= onehot4(win);
              {s2, s1} <= win;
              cnt      <= '0;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (busy) begin
        dout     <= e;
        dout_src <= {s2, s1};
        dout_vld <= 1'b1;
      end else begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter with a behavioural
// round-robin model and an emulated 4x1 mux on e.
module tb_mux4_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1, s2;
  logic [3:0] e;
  logic       busy;
  logic [3:0] dout;
  logic       dout_vld;
  logic [1:0] dout_src;

  logic [3:0] data [4];

  int cmp = 0;
  int bad = 0;

  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  bit m_vld   = 1'b0;

  typedef struct {
    int d;
    int src;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  assign e = data[{s2, s1}];

  mux4_arbiter #(.MAX_HOLD(MH), .CW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .s1       (s1),
    .s2       (s2),
    .e        (e),
    .busy     (busy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_src (dout_src)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int search(input int from, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(from + i) % 4]) return (from + i) % 4;
    end
    return -1;
  endfunction

  // Reference: who owns the mux after this edge, given req at the edge.
  task automatic model_edge();
    exp_t x;
    if (m_owner >= 0) begin
      x.d   = int'(data[m_owner]);
      x.src = m_owner;
      q.push_back(x);
    end
    m_vld = (m_owner >= 0);
    if (m_owner < 0) begin
      m_owner = search(m_ptr, req);
      m_held  = 1;
      if (m_owner >= 0) m_sel = m_owner;
    end else if (!req[m_owner] || m_held == MH) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = search(m_ptr, req);
      m_held  = 1;
      if (m_owner >= 0) m_sel = m_owner;
    end else begin
      m_held++;
    end
  endtask

  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    chk("gnt", gnt, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("sel", {s2, s1}, m_sel);
    chk("busy", busy, m_owner >= 0);
    chk("dout_vld", dout_vld, m_vld);
    req = r;
    for (int i = 0; i < 4; i++) data[i] = 4'($urandom);
    @(posedge clk);
    model_edge();
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_vld) begin
      if (q.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL capture: got dout_vld=1 expected no pending sample");
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("dout", dout, x.d);
        chk("dout_src", dout_src, x.src);
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) data[i] = 4'(i + 5);
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_s1", s1, 0);
    chk("rst_s2", s2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_dout_src", dout_src, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();

    repeat (3) cycle(4'b0010);
    repeat (4) cycle(4'b0000);

    repeat (20) cycle(4'b1111);
    repeat (2) cycle(4'b0000);

    repeat (10) cycle(4'b0001);
    repeat (2) cycle(4'b0000);

    repeat (3) cycle(4'b1000);
    repeat (2) cycle(4'b1001);
    repeat (3) cycle(4'b0001);
    repeat (2) cycle(4'b0000);

    repeat (3) cycle(4'b0011);
    cycle(4'b0010);
    repeat (3) cycle(4'b0011);
    repeat (2) cycle(4'b0000);

    repeat (3) cycle(4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_s1", s1, 0);
    chk("arst_s2", s2, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dout_vld", dout_vld, 0);
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_sel   = 0;
    m_vld   = 1'b0;
    q.delete();
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1 chk("arst_first_A", gnt, 4'b0001);
    repeat (6) cycle(4'b1111);

    r = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cycle(r);
    end

    repeat (8) cycle(4'b0000);
    chk("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
